// File: rtl/otter_bru_pkg.sv
// Shared types and constants for the OTTER branch resolve unit.
package otter_bru_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bru_state_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/otter_branch_cmp.sv
// Combinational EQ/LT/LTU comparator with RV32I branch funct3 decode.
module otter_branch_cmp
  import otter_bru_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            eq_o,
  output logic            lt_o,
  output logic            ltu_o,
  output logic            taken_o,
  output logic            illegal_o
);

  assign eq_o  = (rs1_i == rs2_i);
  assign lt_o  = ($signed(rs1_i) < $signed(rs2_i));
  assign ltu_o = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = eq_o;
      BNE:     taken_o = ~eq_o;
      BLT:     taken_o = lt_o;
      BGE:     taken_o = ~lt_o;
      BLTU:    taken_o = ltu_o;
      BGEU:    taken_o = ~ltu_o;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_branch_resolve_unit.sv
// Registered branch resolution with mispredict flush and post-flush squash window.
// Optional performance counters enabled by defining BRU_PERF_CNT_EN.
module otter_branch_resolve_unit
  import otter_bru_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            IN_VALID,
  input  logic [XLEN-1:0] IN_RS1,
  input  logic [XLEN-1:0] IN_RS2,
  input  logic [2:0]      IN_FUNCT3,
  input  logic            IN_PRED_TAKEN,
  input  logic [XLEN-1:0] IN_PC,
  input  logic [XLEN-1:0] IN_IMM,
  output logic            OUT_VALID,
  output logic            OUT_TAKEN,
  output logic [XLEN-1:0] OUT_TARGET,
  output logic            OUT_MISPREDICT,
  output logic            OUT_FLUSH,
  output logic            OUT_ILLEGAL,
  output logic            BR_EQ,
  output logic            BR_LT,
  output logic            BR_LTU
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] PERF_BR_CNT,
  output logic [CNT_W-1:0] PERF_MISS_CNT
`endif
);

  localparam int unsigned SqW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  bru_state_t     state_q, state_d;
  logic [SqW-1:0] sq_cnt_q, sq_cnt_d;

  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            misp_q, misp_d;
  logic            illegal_q, illegal_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;

  logic cmp_eq, cmp_lt, cmp_ltu, cmp_taken, cmp_illegal;
  logic accept, mispredict;

  otter_branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .rs1_i    (IN_RS1),
    .rs2_i    (IN_RS2),
    .funct3_i (IN_FUNCT3),
    .eq_o     (cmp_eq),
    .lt_o     (cmp_lt),
    .ltu_o    (cmp_ltu),
    .taken_o  (cmp_taken),
    .illegal_o(cmp_illegal)
  );

  assign accept     = IN_VALID & ~STALL & (state_q == RUN);
  assign mispredict = accept & ~cmp_illegal & (cmp_taken != IN_PRED_TAKEN);

  always_comb begin
    state_d   = state_q;
    sq_cnt_d  = sq_cnt_q;
    valid_d   = valid_q;
    taken_d   = taken_q;
    target_d  = target_q;
    misp_d    = misp_q;
    illegal_d = illegal_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    // Everything freezes under STALL so a stretched flush is seen exactly once.
    if (!STALL) begin
      valid_d   = accept;
      misp_d    = mispredict;
      illegal_d = accept & cmp_illegal;
      if (accept) begin
        taken_d  = cmp_taken;
        target_d = cmp_taken ? (IN_PC + IN_IMM) : (IN_PC + XLEN'(PC_INC));
        eq_d     = cmp_eq;
        lt_d     = cmp_lt;
        ltu_d    = cmp_ltu;
      end
      unique case (state_q)
        RUN: begin
          if (mispredict && (FLUSH_CYCLES != 0)) begin
            state_d  = SQUASH;
            sq_cnt_d = SqW'(FLUSH_CYCLES);
          end
        end
        SQUASH: begin
          sq_cnt_d = sq_cnt_q - SqW'(1);
          if (sq_cnt_q <= SqW'(1)) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      sq_cnt_q  <= '0;
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      misp_q    <= 1'b0;
      illegal_q <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sq_cnt_q  <= sq_cnt_d;
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      misp_q    <= misp_d;
      illegal_q <= illegal_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
    end
  end

  assign OUT_VALID      = valid_q;
  assign OUT_TAKEN      = taken_q;
  assign OUT_TARGET     = target_q;
  assign OUT_MISPREDICT = misp_q;
  assign OUT_FLUSH      = misp_q;
  assign OUT_ILLEGAL    = illegal_q;
  assign BR_EQ          = eq_q;
  assign BR_LT          = lt_q;
  assign BR_LTU         = ltu_q;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && !cmp_illegal) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispredict) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign PERF_BR_CNT   = br_cnt_q;
  assign PERF_MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_otter_branch_resolve_unit.sv
// Self-checking bench: directed cases plus random traffic against a cycle-level reference model.
module tb_otter_branch_resolve_unit;

  localparam int unsigned FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        in_valid;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic [2:0]  in_f3;
  logic        in_pred;
  logic        out_valid, out_taken, out_misp, out_flush, out_ill;
  logic [31:0] out_target;
  logic        br_eq, br_lt, br_ltu;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br, perf_miss;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid, m_taken, m_misp, m_ill, m_eq, m_lt, m_ltu;
  logic [31:0] m_target;
  int          m_squash;
  logic [31:0] m_br_cnt, m_miss_cnt;

  always #5 clk = ~clk;

  otter_branch_resolve_unit #(
    .XLEN        (32),
    .FLUSH_CYCLES(FLUSH),
    .CNT_W       (32)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .STALL         (stall),
    .IN_VALID      (in_valid),
    .IN_RS1        (in_rs1),
    .IN_RS2        (in_rs2),
    .IN_FUNCT3     (in_f3),
    .IN_PRED_TAKEN (in_pred),
    .IN_PC         (in_pc),
    .IN_IMM        (in_imm),
    .OUT_VALID     (out_valid),
    .OUT_TAKEN     (out_taken),
    .OUT_TARGET    (out_target),
    .OUT_MISPREDICT(out_misp),
    .OUT_FLUSH     (out_flush),
    .OUT_ILLEGAL   (out_ill),
    .BR_EQ         (br_eq),
    .BR_LT         (br_lt),
    .BR_LTU        (br_ltu)
`ifdef BRU_PERF_CNT_EN
    ,
    .PERF_BR_CNT   (perf_br),
    .PERF_MISS_CNT (perf_miss)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0;
    m_eq = 0; m_lt = 0; m_ltu = 0; m_target = 0;
    m_squash = 0; m_br_cnt = 0; m_miss_cnt = 0;
  endtask

  task automatic check_all();
    chk("valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("mispredict", {31'd0, out_misp}, {31'd0, m_misp});
    chk("flush", {31'd0, out_flush}, {31'd0, m_misp});
    chk("illegal", {31'd0, out_ill}, {31'd0, m_ill});
    if (m_valid) begin
      chk("taken", {31'd0, out_taken}, {31'd0, m_taken});
      chk("target", out_target, m_target);
      chk("br_eq", {31'd0, br_eq}, {31'd0, m_eq});
      chk("br_lt", {31'd0, br_lt}, {31'd0, m_lt});
      chk("br_ltu", {31'd0, br_ltu}, {31'd0, m_ltu});
    end
`ifdef BRU_PERF_CNT_EN
    chk("perf_br", perf_br, m_br_cnt);
    chk("perf_miss", perf_miss, m_miss_cnt);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic p, input logic [31:0] pc,
                      input logic [31:0] imm, input logic st);
    logic acc, eq, lt, ltu, tk, ill;
    in_valid = v; in_rs1 = a; in_rs2 = b; in_f3 = f3; in_pred = p;
    in_pc = pc; in_imm = imm; stall = st;
    if (!st) begin
      acc = v && (m_squash == 0);
      eq  = (a == b);
      ltu = (a < b);
      lt  = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
      ill = 0;
      case (f3)
        3'd0: tk = eq;
        3'd1: tk = !eq;
        3'd4: tk = lt;
        3'd5: tk = !lt;
        3'd6: tk = ltu;
        3'd7: tk = !ltu;
        default: begin tk = 0; ill = 1; end
      endcase
      if (m_squash > 0) m_squash--;
      m_valid = acc;
      m_misp  = acc && !ill && (tk != p);
      m_ill   = acc && ill;
      if (acc) begin
        m_taken  = tk;
        m_target = tk ? pc + imm : pc + 32'd4;
        m_eq = eq; m_lt = lt; m_ltu = ltu;
        if (!ill) m_br_cnt++;
      end
      if (m_misp) begin
        m_squash = FLUSH;
        m_miss_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; stall = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_f3 = 0;
    in_pred = 0; in_pc = 0; in_imm = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    chk("rst_target", out_target, 32'h0);
    rst = 0;

    // BEQ taken, predicted not-taken: flush, then two squashed inputs, third resolved
    step(1, 32'h5, 32'h5, 3'd0, 0, 32'h100, 32'h20, 0);
    chk("beq_target", out_target, 32'h120);
    chk("beq_flush", {31'd0, out_flush}, 32'd1);
    step(1, 32'h1, 32'h2, 3'd0, 0, 32'h104, 32'h8, 0);
    chk("squash1", {31'd0, out_valid}, 32'd0);
    step(1, 32'h1, 32'h2, 3'd0, 0, 32'h108, 32'h8, 0);
    chk("squash2", {31'd0, out_valid}, 32'd0);
    step(1, 32'h1, 32'h2, 3'd0, 0, 32'h10C, 32'h8, 0);
    chk("post_squash", {31'd0, out_valid}, 32'd1);

    // Signed vs unsigned ordering of 0xFFFFFFFF and 1
    step(1, 32'hFFFF_FFFF, 32'h1, 3'd4, 1, 32'h200, 32'h40, 0);
    chk("blt_lt", {31'd0, br_lt}, 32'd1);
    chk("blt_ltu", {31'd0, br_ltu}, 32'd0);
    step(1, 32'hFFFF_FFFF, 32'h1, 3'd6, 1, 32'h204, 32'h40, 0);
    chk("bltu_flush", {31'd0, out_flush}, 32'd1);
    chk("bltu_target", out_target, 32'h208);

    // Stall right after the squash begins: flush held for 4 samples
    idle(); idle();
    step(1, 32'h7, 32'h3, 3'd1, 0, 32'h300, 32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h7, 32'h7, 3'd0, 0, 32'h400, 32'h10, 1);
      chk("stall_flush", {31'd0, out_flush}, 32'd1);
    end
    idle();
    chk("flush_drop", {31'd0, out_flush}, 32'd0);
    idle(); idle();

    // Illegal funct3 and target wrap
    step(1, 32'h9, 32'h9, 3'd2, 1, 32'h500, 32'h10, 0);
    chk("ill_flag", {31'd0, out_ill}, 32'd1);
    chk("ill_taken", {31'd0, out_taken}, 32'd0);
    step(1, 32'h9, 32'h9, 3'd1, 0, 32'hFFFF_FFFC, 32'h10, 0);
    chk("wrap_target", out_target, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      logic [2:0]  f;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 4)
                                                                         : $urandom);
      f = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, a, b, f, 1'($urandom_range(0, 1)), $urandom, $urandom,
           $urandom_range(0, 9) < 2);
    end

    // Asynchronous reset in the middle of a squash window
    idle(); idle(); idle();
    step(1, 32'h1, 32'h1, 3'd0, 0, 32'h600, 32'h4, 0);
    idle();
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_target", out_target, 32'h0);
    #2 rst = 0;
    step(1, 32'h3, 32'h4, 3'd5, 0, 32'h700, 32'h8, 0);
    chk("after_rst_accept", {31'd0, out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
